// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment display driver and its scan decoder.
// Segment patterns are active-low on [6:0] = g..a.
package seg_pkg;

    localparam logic [6:0] NUM_0     = 7'h40;
    localparam logic [6:0] NUM_1     = 7'h79;
    localparam logic [6:0] NUM_2     = 7'h24;
    localparam logic [6:0] NUM_3     = 7'h30;
    localparam logic [6:0] NUM_4     = 7'h19;
    localparam logic [6:0] NUM_5     = 7'h12;
    localparam logic [6:0] NUM_6     = 7'h02;
    localparam logic [6:0] NUM_7     = 7'h78;
    localparam logic [6:0] NUM_8     = 7'h00;
    localparam logic [6:0] NUM_9     = 7'h10;
    localparam logic [6:0] LINE      = 7'h3F;
    localparam logic [6:0] LIT_OUT   = 7'h7F;
    localparam logic [6:0] ALL_LIGHT = 7'h00;

    // One-hot digit selects, in scan order (the select rotates right).
    localparam logic [7:0] SEL_BLANK = 8'h80;
    localparam logic [7:0] SEL_HUND  = 8'h40;
    localparam logic [7:0] SEL_TEN   = 8'h20;
    localparam logic [7:0] SEL_UNIT  = 8'h10;
    localparam logic [7:0] SEL_DASH  = 8'h08;
    localparam logic [7:0] SEL_MM    = 8'h04;
    localparam logic [7:0] SEL_P1    = 8'h02;
    localparam logic [7:0] SEL_P2    = 8'h01;

    localparam logic [2:0] SLOT_BLANK = 3'd7;
    localparam logic [2:0] SLOT_UNIT  = 3'd4;
    localparam logic [2:0] SLOT_DASH  = 3'd3;
    localparam logic [2:0] SLOT_LAST  = 3'd0;

    localparam int SLOT_LEN = 1000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_WAIT,
        ST_ASSEMBLE
    } scanState_t;

    function automatic logic [7:0] rotr8(input logic [7:0] v);
        return {v[0], v[7:1]};
    endfunction

    // Digit order: [5]=hundreds cm ... [0]=0.01 mm; 20 bits holds up to 999999.
    function automatic logic [19:0] bcdToBin(input logic [5:0][3:0] d);
        return 20'(d[5]) * 20'd100000 + 20'(d[4]) * 20'd10000 + 20'(d[3]) * 20'd1000
             + 20'(d[2]) * 20'd100    + 20'(d[1]) * 20'd10    + 20'(d[0]);
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational reverse lookup from an active-low 7-segment pattern to a BCD digit.
// Anything that is not one of the ten digit glyphs reports is_digit = 0.
module seg7_to_bcd
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       is_digit
);

    always_comb begin
        digit    = 4'd0;
        is_digit = 1'b1;
        case (seg)
            NUM_0:   digit = 4'd0;
            NUM_1:   digit = 4'd1;
            NUM_2:   digit = 4'd2;
            NUM_3:   digit = 4'd3;
            NUM_4:   digit = 4'd4;
            NUM_5:   digit = 4'd5;
            NUM_6:   digit = 4'd6;
            NUM_7:   digit = 4'd7;
            NUM_8:   digit = 4'd8;
            NUM_9:   digit = 4'd9;
            default: is_digit = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Watches the multiplexed 7-segment scan bus and rebuilds the displayed 19-bit distance,
// pulsing data_valid per clean frame and decode_err whenever a frame has to be abandoned.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int SETTLE_CYC = 500
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  sel_in,
    input  logic [7:0]  seg_in,
    output logic [18:0] data_out,
    output logic        data_valid,
    output logic        decode_err
);

    localparam int            CW       = $clog2(SETTLE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    scanState_t       state_q;
    logic [7:0]       sel_q;
    logic [7:0]       segSample_q;
    logic [CW-1:0]    cnt_q;
    logic [2:0]       slotIdx_q;
    logic [5:0][3:0]  digits_q;
    logic [18:0]      dataOut_q;
    logic             valid_q;
    logic             err_q;

    logic [3:0]       bcdDigit;
    logic             isDigit;
    logic             selChanged;
    logic             rotOk;
    logic             patternOk;
    logic             dpOk;
    logic             isDigitSlot;
    logic [2:0]       digitPos;
    logic [19:0]      frameSum;

    seg7_to_bcd uSegToBcd (
        .seg      (segSample_q[6:0]),
        .digit    (bcdDigit),
        .is_digit (isDigit)
    );

    // Slot checks run on the registered segment sample so seg may lag sel by a cycle.
    always_comb begin
        selChanged  = (sel_in != sel_q);
        rotOk       = (sel_in == rotr8(sel_q));
        isDigitSlot = (slotIdx_q != SLOT_BLANK) && (slotIdx_q != SLOT_DASH);
        digitPos    = (slotIdx_q > SLOT_DASH) ? (slotIdx_q - 3'd1) : slotIdx_q;
        dpOk        = (segSample_q[7] == 1'b0) == (slotIdx_q == SLOT_UNIT);
        patternOk   = isDigit;
        if (slotIdx_q == SLOT_BLANK) begin
            patternOk = (segSample_q[6:0] == LIT_OUT);
        end else if (slotIdx_q == SLOT_DASH) begin
            patternOk = (segSample_q[6:0] == LINE);
        end
        frameSum    = bcdToBin(digits_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            segSample_q <= '0;
            cnt_q       <= '0;
            slotIdx_q   <= '0;
            digits_q    <= '0;
            dataOut_q   <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sel_q   <= sel_in;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (selChanged && (sel_in == SEL_BLANK)) begin
                        state_q   <= ST_SETTLE;
                        cnt_q     <= CNT_ONE;
                        slotIdx_q <= SLOT_BLANK;
                    end
                end
                ST_SETTLE: begin
                    if (selChanged) begin
                        state_q  <= ST_IDLE;
                        err_q    <= 1'b1;
                        digits_q <= '0;
                        cnt_q    <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        segSample_q <= seg_in;
                        state_q     <= ST_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_SAMPLE: begin
                    if (selChanged || !patternOk || !dpOk) begin
                        state_q  <= ST_IDLE;
                        err_q    <= 1'b1;
                        digits_q <= '0;
                        cnt_q    <= '0;
                    end else begin
                        if (isDigitSlot) begin
                            digits_q[digitPos] <= bcdDigit;
                        end
                        state_q <= (slotIdx_q == SLOT_LAST) ? ST_ASSEMBLE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (selChanged) begin
                        if (rotOk) begin
                            state_q   <= ST_SETTLE;
                            cnt_q     <= CNT_ONE;
                            slotIdx_q <= slotIdx_q - 3'd1;
                        end else begin
                            state_q  <= ST_IDLE;
                            err_q    <= 1'b1;
                            digits_q <= '0;
                            cnt_q    <= '0;
                        end
                    end
                end
                // With a long settle time the next blank slot can begin in this very cycle.
                ST_ASSEMBLE: begin
                    if (frameSum[19] || (selChanged && !rotOk)) begin
                        state_q  <= ST_IDLE;
                        err_q    <= 1'b1;
                        digits_q <= '0;
                        cnt_q    <= '0;
                    end else begin
                        dataOut_q <= frameSum[18:0];
                        valid_q   <= 1'b1;
                        if (selChanged) begin
                            state_q   <= ST_SETTLE;
                            cnt_q     <= CNT_ONE;
                            slotIdx_q <= slotIdx_q - 3'd1;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_out   = dataOut_q;
    assign data_valid = valid_q;
    assign decode_err = err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: a behavioural scan driver feeds frames with a short
// settle time, and a negedge monitor counts valid/error pulses for the checks.
module tb_seg_scan_decoder;

    localparam int SETTLE = 20;
    localparam int SLOT   = 40;
    localparam int NONE   = -1;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  sel_in;
    logic [7:0]  seg_in;
    logic [18:0] data_out;
    logic        data_valid;
    logic        decode_err;

    int checkCount = 0;
    int errorCount = 0;
    int validCount = 0;
    int errCount = 0;
    int bothHigh = 0;
    int longPulse = 0;
    int cycleCount = 0;
    int lastValidCycle = 0;
    int prevValidCycle = 0;
    logic [18:0] lastValue = '0;
    logic prevValid = 1'b0;
    logic prevErr = 1'b0;
    int v0;
    int e0;

    always #10 clk = ~clk;

    seg_scan_decoder #(.SETTLE_CYC(SETTLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .sel_in     (sel_in),
        .seg_in     (seg_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .decode_err (decode_err)
    );

    always @(posedge clk) cycleCount++;

    // Pulse bookkeeping, sampled half a cycle away from the active edge.
    always @(negedge clk) begin
        if (data_valid) begin
            validCount++;
            lastValue      = data_out;
            prevValidCycle = lastValidCycle;
            lastValidCycle = cycleCount;
        end
        if (decode_err) errCount++;
        if (data_valid && decode_err) bothHigh++;
        if ((data_valid && prevValid) || (decode_err && prevErr)) longPulse++;
        prevValid = data_valid;
        prevErr   = decode_err;
    end

    function automatic logic [6:0] segOf(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One slot: sel changes first, seg follows one cycle later, slot lasts len cycles.
    task automatic driveSlot(input logic [7:0] sel, input logic [7:0] seg, input int len);
        @(posedge clk); #1 sel_in = sel;
        @(posedge clk); #1 seg_in = seg;
        repeat (len - 2) @(posedge clk);
    endtask

    task automatic applyStimulus(input int value, input int shortSlot, input int badSlot,
                                 input logic [7:0] badSeg, input int rstSlot);
        int d [8];
        logic [7:0] sel;
        logic [7:0] seg;
        int len;
        d[7] = 0;
        d[6] = (value / 100000) % 10;
        d[5] = (value / 10000) % 10;
        d[4] = (value / 1000) % 10;
        d[3] = 0;
        d[2] = (value / 100) % 10;
        d[1] = (value / 10) % 10;
        d[0] = value % 10;
        for (int s = 7; s >= 0; s--) begin
            sel = 8'h01 << s;
            if (s == 7)      seg = 8'hFF;
            else if (s == 3) seg = 8'hBF;
            else if (s == 4) seg = {1'b0, segOf(d[s])};
            else             seg = {1'b1, segOf(d[s])};
            if (s == badSlot) seg = badSeg;
            len = (s == shortSlot) ? 12 : SLOT;
            if (s == rstSlot) begin
                @(posedge clk); #1 sel_in = sel;
                @(posedge clk); #1 seg_in = seg; rst = 1'b1;
                @(posedge clk); #1 rst = 1'b0;
                @(negedge clk);
                checkOutput("rst_mid_data", 32'(data_out), 0);
                checkOutput("rst_mid_valid", 32'(data_valid), 0);
                checkOutput("rst_mid_err", 32'(decode_err), 0);
                repeat (len - 3) @(posedge clk);
            end else begin
                driveSlot(sel, seg, len);
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        sel_in = 8'h00;
        seg_in = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_data", 32'(data_out), 0);
        checkOutput("reset_valid", 32'(data_valid), 0);
        checkOutput("reset_err", 32'(decode_err), 0);
        @(posedge clk); #1 rst = 1'b0;
        $display("[TB] reset released");

        v0 = validCount; e0 = errCount;
        applyStimulus(123456, NONE, NONE, 8'h00, NONE);
        checkOutput("f1_valid_cnt", validCount - v0, 1);
        checkOutput("f1_value", 32'(lastValue), 123456);
        checkOutput("f1_data_out", 32'(data_out), 123456);
        checkOutput("f1_err_cnt", errCount - e0, 0);

        v0 = validCount;
        applyStimulus(123456, NONE, NONE, 8'h00, NONE);
        checkOutput("f2_valid_cnt", validCount - v0, 1);
        checkOutput("f2_interval", lastValidCycle - prevValidCycle, 8 * SLOT);

        v0 = validCount;
        applyStimulus(0, NONE, NONE, 8'h00, NONE);
        checkOutput("zero_valid_cnt", validCount - v0, 1);
        checkOutput("zero_value", 32'(lastValue), 0);

        v0 = validCount;
        applyStimulus(524287, NONE, NONE, 8'h00, NONE);
        checkOutput("max_valid_cnt", validCount - v0, 1);
        checkOutput("max_value", 32'(lastValue), 524287);

        v0 = validCount; e0 = errCount;
        applyStimulus(123456, NONE, 1, 8'hFF, NONE);
        checkOutput("badseg_err_cnt", errCount - e0, 1);
        checkOutput("badseg_valid_cnt", validCount - v0, 0);
        checkOutput("badseg_retained", 32'(data_out), 524287);
        v0 = validCount;
        applyStimulus(777, NONE, NONE, 8'h00, NONE);
        checkOutput("badseg_next_value", 32'(lastValue), 777);
        checkOutput("badseg_next_cnt", validCount - v0, 1);

        v0 = validCount; e0 = errCount;
        driveSlot(8'h80, 8'hFF, SLOT);
        driveSlot(8'h40, {1'b1, segOf(1)}, SLOT);
        driveSlot(8'h20, {1'b1, segOf(2)}, SLOT);
        driveSlot(8'h04, {1'b1, segOf(4)}, SLOT);
        driveSlot(8'h02, {1'b1, segOf(5)}, SLOT);
        driveSlot(8'h01, {1'b1, segOf(6)}, SLOT);
        checkOutput("rot_err_cnt", errCount - e0, 1);
        checkOutput("rot_valid_cnt", validCount - v0, 0);
        applyStimulus(4242, NONE, NONE, 8'h00, NONE);
        checkOutput("rot_resync_value", 32'(lastValue), 4242);
        checkOutput("rot_resync_cnt", validCount - v0, 1);

        e0 = errCount;
        driveSlot(8'h80, 8'hFF, SLOT);
        driveSlot(8'h40, {1'b1, segOf(1)}, SLOT);
        driveSlot(8'h30, {1'b1, segOf(2)}, SLOT);
        checkOutput("onehot_err_cnt", errCount - e0, 1);

        v0 = validCount; e0 = errCount;
        applyStimulus(0, 5, NONE, 8'h00, NONE);
        checkOutput("short_err_cnt", errCount - e0, 1);
        checkOutput("short_valid_cnt", validCount - v0, 0);
        applyStimulus(31415, NONE, NONE, 8'h00, NONE);
        checkOutput("short_next_value", 32'(lastValue), 31415);

        v0 = validCount; e0 = errCount;
        applyStimulus(600000, NONE, NONE, 8'h00, NONE);
        checkOutput("ovf_err_cnt", errCount - e0, 1);
        checkOutput("ovf_valid_cnt", validCount - v0, 0);
        checkOutput("ovf_retained", 32'(data_out), 31415);

        e0 = errCount;
        applyStimulus(123456, NONE, 5, {1'b0, segOf(2)}, NONE);
        checkOutput("dp_err_cnt", errCount - e0, 1);

        applyStimulus(123456, NONE, NONE, 8'h00, 2);
        v0 = validCount; e0 = errCount;
        applyStimulus(123456, NONE, NONE, 8'h00, NONE);
        checkOutput("post_rst_value", 32'(lastValue), 123456);
        checkOutput("post_rst_cnt", validCount - v0, 1);
        checkOutput("post_rst_err", errCount - e0, 0);

        repeat (5) @(posedge clk);
        checkOutput("valid_err_overlap", bothHigh, 0);
        checkOutput("pulse_width", longPulse, 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

- Observes the multiplexed 7-segment scan bus (`sel`/`seg`) produced by the display driver and reconstructs the displayed 19-bit distance value.
- Decodes each digit slot back to BCD, checks the fixed frame layout, assembles the six digits into a binary word, and emits a one-cycle valid strobe per clean frame.
- Sits on the loopback/self-test path beside the display driver, in the same clock domain.

## Interface
Parameters:
- `SETTLE_CYC`, default 500: cycles after a `sel_in` change before the segments are sampled; must be ≥2 and smaller than the scan slot length (1000 cycles).

Ports:
- `clk`  in  1  50 MHz system clock.
- `rst`  in  1  Reset: synchronous, active-high.
- `sel_in`  in  8  Digit select.
  - One-hot, active-high.
  - Rotates right: `1000_0000` → `0100_0000` → … → `0000_0001` → `1000_0000`.
- `seg_in`  in  8  Segment lines.
  - Active-low.
  - `[6:0]` = g..a; `[7]` = decimal point (0 = lit).
- `data_out`  out  19  Last decoded value, in units of 0.01 mm.
- `data_valid`  out  1  One-cycle pulse when `data_out` is updated.
- `decode_err`  out  1  One-cycle pulse when a frame is aborted.

## Operation
- Inputs are synchronous to `clk`; no synchronizer.
- Frame slot layout, by `sel_in`:
  - bit7 = blank, `7F`.
  - bit6 = hundreds of cm.
  - bit5 = tens of cm.
  - bit4 = units of cm, with dp lit.
  - bit3 = dash, `3F`.
  - bit2 = 1 mm.
  - bit1 = 0.1 mm.
  - bit0 = 0.01 mm.
- Digit patterns for 0-9 are `40 79 24 30 19 12 02 78 00 10` on `seg_in[6:0]`. Any other pattern in a digit slot is an error.
- States:
  - IDLE: wait for `sel_in` to change to `1000_0000`, then go to SETTLE with slot index 7.
  - SETTLE: count cycles since the last `sel_in` change. At count `SETTLE_CYC-1`, go to SAMPLE.
  - SAMPLE (1 cycle): check the slot pattern and store the digit.
    - dp must be lit only in slot 4.
    - Slot 7 must read `7F`; slot 3 must read `3F`.
    - If slot 0 was sampled, go to ASSEMBLE; otherwise go to WAIT.
  - WAIT: wait for a `sel_in` change.
    - If the new value equals the old value rotated right by one, go to SETTLE.
    - Any other value is an error.
  - ASSEMBLE (1 cycle): compute hund·100000 + ten·10000 + unit·1000 + p1·100 + p2·10 + p3 with 20-bit arithmetic.
    - If the sum ≤ 524287: load `data_out` and pulse `data_valid`.
    - Otherwise: error (overflow); `data_out` is unchanged.
    - Then return to WAIT, expecting `1000_0000`, and continue with the next frame.
- Error handling, from any error:
  - pulse `decode_err`;
  - discard the partial digits;
  - go to IDLE;
  - `data_out` is retained.
- Error sources:
  - `sel_in` not one-hot;
  - wrong rotation;
  - `sel_in` changes during SETTLE (slot shorter than `SETTLE_CYC`);
  - bad pattern or dp;
  - overflow.

## Timing
- Reset values: `data_out` = 0, `data_valid` = 0, `decode_err` = 0, state IDLE, stored `sel` = 0, counter = 0.
- Change detection: compare `sel_in` with a registered copy. The first cycle of a new value counts as count 0.
- Sampling is registered: `seg_in` is sampled in the cycle where count = `SETTLE_CYC-1`.
  - This tolerates the driver's one-cycle `seg` lag behind `sel`.
- Latency:
  - `data_out`/`data_valid` update on the 2nd rising edge after the edge that samples slot 0.
  - `decode_err` asserts on the edge after the offending cycle.
- `data_valid` and `decode_err` are never high together, and each is high for exactly one cycle.
- Continuous scanning yields one `data_valid` every 8 slots.
- Simultaneous reset and any event: reset wins.
- Reset mid-frame: the partial frame is lost; the next complete frame starting at `1000_0000` decodes normally.

## Structure
Shared package `seg_pkg` holds:
- the 7-segment constants `NUM_0`..`NUM_9`, `LINE`, `LIT_OUT`, `ALL_LIGHT`;
- the slot one-hot constants;
- the state enum.

The display driver and this block both use it.

Sub-module `seg7_to_bcd` is purely combinational:
- input: `seg[6:0]`;
- outputs: `digit[3:0]` and `is_digit`;
- instantiated once.

## Test plan
- Loopback with the display driver, `data_in` = 19'd123456 → after the first full frame, `data_valid` pulses once, `data_out` = 123456, no `decode_err`; it repeats every 8000 cycles.
- Loopback with `data_in` = 0, then 524287 → `data_out` = 0, then 524287, each with one `data_valid` pulse.
- Force slot 1 `seg_in[6:0]` = `7F` → `decode_err` pulse, no `data_valid` for that frame, `data_out` is retained; the next clean frame decodes.
- Drive `sel_in` from `0010_0000` straight to `0000_0100` → `decode_err`, resync at the next `1000_0000`, the following frame is valid.
- With `SETTLE_CYC` = 500, drive a 300-cycle slot → `decode_err`. Separately, force hundreds = 6 with the rest 0 (600000) → overflow `decode_err`, `data_out` unchanged.
- Assert `rst` during slot 2 → all outputs 0 the next cycle; the next full frame of 123456 decodes correctly.
